// File: rtl/pipeif_pkg.sv
// Shared encodings and types for the pipeif fetch block.
// The PIPEIF_MISALIGN_EN macro is consumed by pipeif_fetch_q, not here.
package pipeif_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pipeif_fetch_q_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface pipeif_fetch_q_if #(parameter int AW = 32) ();

  // Handshake: the master raises imem_req with imem_addr and holds both
  // unchanged until a cycle with imem_ack=1 completes the transfer; imem_rdata
  // is valid only in that cycle, and imem_ack is meaningless while imem_req=0.
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/pipeif_queue.sv
// Synchronous flushable FIFO whose head is a register loaded from storage,
// so the head value holds its last content while the queue is empty.
module pipeif_queue #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_nxt;
  logic [CW-1:0] cnt_left, cnt_nxt;
  logic          do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & ~flush & (~full | do_pop);
    cnt_left = count - CW'(do_pop);
    cnt_nxt  = cnt_left + CW'(do_push);
    rptr_nxt = rptr + PW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(do_push);
      rptr  <= rptr_nxt;
      count <= cnt_nxt;
      // With older entries remaining, the next head is already in storage;
      // otherwise it is the word being pushed right now.
      if (cnt_left != '0)
        head <= mem[rptr_nxt];
      else if (do_push)
        head <= wdata;
    end
  end

endmodule

// File: rtl/pipeif_fetch_q.sv
// Instruction fetch stage: PC selection, variable-latency imem handshake and a
// prefetch queue drained by ID. Optional macro: PIPEIF_MISALIGN_EN.
module pipeif_fetch_q
  import pipeif_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [1:0]            pcsrc,
  input  logic [AW-1:0]         bpc,
  input  logic [AW-1:0]         rpc,
  input  logic [AW-1:0]         jpc,
  pipeif_fetch_q_if.master      imem,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [31:0]           ins,
  output logic [AW-1:0]         ins_pc,
  output logic [AW-1:0]         pc4,
`ifdef PIPEIF_MISALIGN_EN
  output logic                  ins_misalign,
`endif
  output fetch_state_t          dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]   ins;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
`ifdef PIPEIF_MISALIGN_EN
    logic          mis;
`endif
  } entry_t;

  fetch_state_t  state;
  logic [AW-1:0] fpc, areq, raw, target;
  logic          req_q, redirect, ack, push, pop, misaligned, mis_push, halt;
  logic          room_idle, room_ack;
  logic [CW-1:0] q_count, count_after;
  logic          q_full, q_empty;
  entry_t        q_in, q_head;

  always_comb begin
    redirect = (pcsrc != PCSRC_SEQ);
    case (pcsrc)
      PCSRC_BR: raw = bpc;
      PCSRC_JR: raw = rpc;
      default:  raw = jpc;
    endcase
`ifdef PIPEIF_MISALIGN_EN
    target     = raw;
    misaligned = redirect & (raw[1:0] != 2'b00);
`else
    target     = raw & ~AW'(3);
    misaligned = 1'b0;
`endif
    ack  = req_q & imem.imem_ack;
    pop  = ins_valid & ins_ready & ~redirect;
    push = ~redirect & (((state == REQ) & ack) | mis_push);
    count_after = q_count + CW'(push) - CW'(pop);
    room_idle = ~q_full | pop;
    room_ack  = (count_after < CW'(DEPTH));
  end

  always_comb begin
    q_in     = '0;
    q_in.ins = imem.imem_rdata;
    q_in.pc  = areq;
    q_in.pc4 = areq + AW'(4);
`ifdef PIPEIF_MISALIGN_EN
    if (mis_push) begin
      q_in.ins = NOP_INS;
      q_in.pc  = fpc;
      q_in.pc4 = fpc + AW'(4);
      q_in.mis = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      fpc   <= RESET_PC;
      areq  <= '0;
      req_q <= 1'b0;
    end else if (redirect) begin
      fpc <= target;
      case (state)
        REQ: begin
          // An ack in the redirect cycle belongs to the stale path and is dropped.
          state <= ack ? IDLE : DROP;
          req_q <= ~ack;
        end
        DROP: begin
          state <= ack ? IDLE : DROP;
          req_q <= ~ack;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (room_idle && !halt) begin
            areq  <= fpc;
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            fpc <= areq + AW'(4);
            if (room_ack) begin
              areq <= areq + AW'(4);
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPEIF_MISALIGN_EN
  // A misaligned target parks the stage until the next redirect; its
  // NOP marker entry is queued one cycle after the redirect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mis_push <= 1'b0;
      halt     <= 1'b0;
    end else if (redirect) begin
      mis_push <= misaligned;
      halt     <= misaligned;
    end else begin
      mis_push <= 1'b0;
    end
  end
  assign ins_misalign = q_head.mis;
`else
  assign mis_push = 1'b0;
  assign halt     = misaligned;
`endif

  pipeif_queue #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .clrn  (clrn),
    .flush (redirect),
    .push  (push),
    .wdata (q_in),
    .pop   (pop),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = areq;
  assign ins_valid      = ~q_empty;
  assign ins            = q_head.ins;
  assign ins_pc         = q_head.pc;
  assign pc4            = q_head.pc4;
  assign dbg_state      = state;

endmodule

// File: tb/tb_pipeif_fetch_q.sv
// Directed bench for pipeif_fetch_q (DEPTH=4, RESET_PC=0); memory returns
// 32'hC0DE_0000 + address. Covers PIPEIF_MISALIGN_EN when defined.
module tb_pipeif_fetch_q;
  import pipeif_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [1:0]    pcsrc = 2'b11;
  logic [AW-1:0] bpc = 32'hDEAD_BEE1;
  logic [AW-1:0] rpc = 32'h1234_5677;
  logic [AW-1:0] jpc = 32'hFFFF_FFFF;
  logic          ins_ready = 1'b1;
  logic          ins_valid;
  logic [31:0]   ins;
  logic [AW-1:0] ins_pc, pc4;
  fetch_state_t  dbg_state;
  logic          ack_mode = 1'b0;
  logic          ack_man = 1'b1;
  int            n_assert = 0;
  int            n_fail = 0;
  int            acks = 0;
  int            ack_base = 0;
`ifdef PIPEIF_MISALIGN_EN
  logic          ins_misalign;
`endif

  pipeif_fetch_q_if #(.AW(AW)) imem ();

  assign imem.imem_ack   = ack_mode ? imem.imem_req : ack_man;
  assign imem.imem_rdata = 32'hC0DE_0000 + imem.imem_addr;

  pipeif_fetch_q #(.AW(AW), .DEPTH(4), .RESET_PC('0)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .pcsrc        (pcsrc),
    .bpc          (bpc),
    .rpc          (rpc),
    .jpc          (jpc),
    .imem         (imem),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .pc4          (pc4),
`ifdef PIPEIF_MISALIGN_EN
    .ins_misalign (ins_misalign),
`endif
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clrn && imem.imem_req && imem.imem_ack) acks <= acks + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with garbage on every input
    step();
    step();
    chk("rst_req", imem.imem_req, 0);
    chk("rst_addr", imem.imem_addr, 0);
    chk("rst_valid", ins_valid, 0);
    chk("rst_ins", ins, 0);
    chk("rst_pc", ins_pc, 0);
    chk("rst_pc4", pc4, 0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge clk);
    pcsrc = PCSRC_SEQ; ack_man = 1'b0; ack_mode = 1'b1; ins_ready = 1'b1;
    clrn = 1'b1;

    // Zero-wait memory streams one instruction per cycle
    step();
    chk("rel_req", imem.imem_req, 1);
    chk("rel_addr", imem.imem_addr, 0);
    chk("rel_valid", ins_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zw_valid", ins_valid, 1);
      chk("zw_pc", ins_pc, 4 * i);
      chk("zw_pc4", pc4, 4 * i + 4);
      chk("zw_ins", ins, 32'hC0DE_0000 + 4 * i);
    end

    // Jump to 0 while a request is pending: stale request drains in DROP
    ack_mode = 1'b0; pcsrc = PCSRC_J; jpc = 32'h0;
    step();
    chk("j0_valid", ins_valid, 0);
    chk("j0_state", dbg_state, DROP);
    chk("j0_addr", imem.imem_addr, 32'h10);
    pcsrc = PCSRC_SEQ; ins_ready = 1'b0; ack_man = 1'b1;
    step();
    chk("drop_req", imem.imem_req, 0);
    chk("drop_valid", ins_valid, 0);
    ack_man = 1'b0; ack_mode = 1'b1;

    // Stalled ID: queue fills with exactly DEPTH fetches
    step();
    chk("fill_addr", imem.imem_addr, 0);
    ack_base = acks;
    step(); step(); step(); step();
    chk("full_req", imem.imem_req, 0);
    chk("full_acks", acks - ack_base, 4);
    chk("full_valid", ins_valid, 1);
    chk("full_head", ins_pc, 0);
    step();
    chk("full_req2", imem.imem_req, 0);
    ins_ready = 1'b1;
    step();
    chk("pop1_req", imem.imem_req, 1);
    chk("pop1_addr", imem.imem_addr, 32'h10);
    chk("pop1_head", ins_pc, 4);
    ins_ready = 1'b0;
    step();
    chk("pop1_idle", imem.imem_req, 0);
    chk("pop1_acks", acks - ack_base, 5);
    ack_mode = 1'b0; ack_man = 1'b0;

    // Redirect to 0x8, then branch to 0x100 while 0x8 waits for a slow ack
    pcsrc = PCSRC_BR; bpc = 32'h8;
    step();
    chk("b8_valid", ins_valid, 0);
    pcsrc = PCSRC_SEQ;
    step();
    chk("b8_req", imem.imem_req, 1);
    chk("b8_addr", imem.imem_addr, 32'h8);
    pcsrc = PCSRC_BR; bpc = 32'h100;
    step();
    chk("b100_addr", imem.imem_addr, 32'h8);
    chk("b100_valid", ins_valid, 0);
    pcsrc = PCSRC_SEQ;
    step();
    chk("hold_addr", imem.imem_addr, 32'h8);
    chk("hold_req", imem.imem_req, 1);
    ack_man = 1'b1;
    step();
    chk("stale_req", imem.imem_req, 0);
    chk("stale_valid", ins_valid, 0);
    ack_man = 1'b0;
    step();
    chk("b100_req", imem.imem_req, 1);
    chk("b100_raddr", imem.imem_addr, 32'h100);
    ack_man = 1'b1; ins_ready = 1'b1;
    step();
    chk("b100_hvalid", ins_valid, 1);
    chk("b100_pc", ins_pc, 32'h100);
    chk("b100_pc4", pc4, 32'h104);
    chk("b100_ins", ins, 32'hC0DE_0100);

    // Jump coincident with ack and pop: nothing pushed, next fetch at target
    pcsrc = PCSRC_J; jpc = 32'h40;
    step();
    chk("jco_valid", ins_valid, 0);
    chk("jco_req", imem.imem_req, 0);
    pcsrc = PCSRC_SEQ; ack_man = 1'b0;
    step();
    chk("jco_valid2", ins_valid, 0);
    chk("jco_addr", imem.imem_addr, 32'h40);
    ins_ready = 1'b0; ack_man = 1'b1;
    step();
    chk("j40_pc", ins_pc, 32'h40);
    chk("j40_pc4", pc4, 32'h44);
    chk("j40_ins", ins, 32'hC0DE_0040);

    // Misaligned jr target 0x102
    ack_man = 1'b0; pcsrc = PCSRC_JR; rpc = 32'h102;
    step();
    chk("jr_valid", ins_valid, 0);
    pcsrc = PCSRC_SEQ; ack_man = 1'b1;
    step();
    ack_man = 1'b0;
`ifdef PIPEIF_MISALIGN_EN
    chk("mis_valid", ins_valid, 1);
    chk("mis_pc", ins_pc, 32'h102);
    chk("mis_pc4", pc4, 32'h106);
    chk("mis_ins", ins, 0);
    chk("mis_flag", ins_misalign, 1);
    chk("mis_req", imem.imem_req, 0);
    step();
    chk("mis_idle1", imem.imem_req, 0);
    step();
    chk("mis_idle2", imem.imem_req, 0);
`else
    chk("jr_req0", imem.imem_req, 0);
    step();
    chk("jr_req", imem.imem_req, 1);
    chk("jr_addr", imem.imem_addr, 32'h100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeif_fetch_q.md
Name: pipeif_fetch_q

Overview:
- Parametrised successor of the single-cycle IF stage.
- Owns the fetch PC and selects the next PC from sequential/branch/jr/jump sources.
- Talks to instruction memory over a variable-latency req/ack handshake.
- Buffers fetched instructions (with pc and pc+4) in a prefetch queue that ID drains with valid/ready.
- A taken control transfer from ID flushes the queue and abandons or discards stale fetches.

Parameters:
- AW, 32, PC/address width (≥8).
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- pcsrc  in  2  next-PC select from ID: 00 sequential, 01 bpc, 10 rpc, 11 jpc. Non-zero means redirect.
- bpc  in  AW  branch target.
- rpc  in  AW  jr target.
- jpc  in  AW  j/jal target.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word.
- ins_valid  out  1  queue head valid.
- ins_ready  in  1  ID accepts head.
- ins  out  32  head instruction.
- ins_pc  out  AW  head PC.
- pc4  out  AW  head PC+4.

Behaviour:
- Reset (clrn=0, async): fpc=RESET_PC, state=IDLE, queue empty. All outputs are 0: imem_req, imem_addr, ins_valid, ins, ins_pc, pc4.
- Reset mid-request abandons the request; memory is reset together with this block.
- Handshake: once imem_req=1, imem_req and imem_addr (from register areq) hold until imem_ack. imem_ack is ignored while imem_req=0.
- Redirect target: pcsrc=01 gives bpc, 10 gives rpc, 11 gives jpc. Target bits [1:0] are forced to 0.
- Redirect priority: a redirect has priority over every other event in the same cycle.
  - fpc ← target.
  - Queue flushed: count=0, pointers cleared. Any pop or push in that cycle is cancelled.
  - ins_valid=0 in the next cycle.
- Slot reservation: issue only if the queue count after this cycle's push/pop is < DEPTH.
- FSM state IDLE (imem_req=0):
  - If space and no redirect: areq←fpc, go to REQ.
- FSM state REQ (imem_req=1, addr=areq), on ack without redirect:
  - Push {imem_rdata, areq, areq+4}; fpc←areq+4.
  - If space remains: areq←areq+4 and stay in REQ (back-to-back; zero-wait memory gives 1 instr/cycle). Otherwise go to IDLE.
- FSM state REQ, redirect cases:
  - Redirect with no ack: go to DROP.
  - Redirect with ack in the same cycle: data is discarded; go to IDLE.
- FSM state DROP (imem_req=1, old areq held):
  - On ack: data discarded, go to IDLE.
  - A further redirect only updates fpc.
- Latency: instruction visible on ins_valid the cycle after its ack. Redirect to first request is 1 cycle from IDLE, or after the stale ack from DROP.
- Pop: when ins_valid & ins_ready & no redirect. Head outputs are registered from queue storage.
- Full: a push and pop in the same cycle keep count. Count never exceeds DEPTH.
- Empty: ins_valid=0; ins/ins_pc/pc4 hold their last value, so ID must not sample them.
- Address arithmetic is modulo 2^AW; wrap-around at the top of memory is silent.

Optional Feature:
- Macro PIPEIF_MISALIGN_EN.
- Defined:
  - A redirect target with bits[1:0]≠0 is not fetched.
  - Next cycle, a single entry {32'h0, target, target+4} is pushed, with output ins_misalign=1 valid alongside the head.
  - The FSM then stays in IDLE until the next redirect.
- Undefined: the ins_misalign port is absent and bits[1:0] are forced to 0.

Decomposition:
- Package pipeif_pkg holds:
  - pcsrc encodings PCSRC_SEQ/BR/JR/J.
  - FSM state type (IDLE, REQ, DROP).
  - NOP_INS=32'h0.
- Sub-module pipeif_queue: synchronous FIFO with flush, width 32+2·AW, depth DEPTH, exposing count/full/empty.

Test Plan:
- Reset: clrn=0 with garbage inputs → all outputs 0. Release → imem_req=1, imem_addr=RESET_PC at the next edge.
- Zero-wait memory (ack=req), ins_ready=1 → ins_pc 0,4,8,12 on consecutive cycles with pc4=ins_pc+4, no bubbles.
- ins_ready=0, DEPTH=4 → exactly 4 acks accepted, then imem_req=0. One pop → exactly one further fetch at 0x10.
- Request to 0x8 with ack delayed 3 cycles; pcsrc=01, bpc=0x100 in cycle 1 → addr holds 0x8 until ack. 0x8 data never appears; next ins_pc=0x100; ins_valid=0 the cycle after redirect.
- Redirect pcsrc=11, jpc=0x40 coincident with ack and pop → queue empty, no push. Next request at 0x40.
- With PIPEIF_MISALIGN_EN, rpc=0x102 → no imem_req. Entry ins=0, ins_pc=0x102, ins_misalign=1 appears, then idle until the next redirect.
